// File: rtl/text_console_writer_if.sv
// ---------------------------------------------------------------------------
// text_console_writer_if
//
// Bundles the two buses of the console writer:
//   - character stream (ch_valid / ch_data / ch_ready), a valid/ready handshake
//     from a keyboard, UART or CPU character source;
//   - character RAM port (vram_we / vram_addr / vram_wdata / vram_rdata), where
//     vram_rdata is an asynchronous read of vram_addr.
//
// Modports:
//   slave  - the console writer: consumes characters, drives the RAM port.
//   master - the environment: character source plus character RAM.
//
// Parameter:
//   AW - character RAM address width.
// ---------------------------------------------------------------------------
interface text_console_writer_if #(
    parameter int AW = 13
);
    logic          ch_valid;
    logic [6:0]    ch_data;
    logic          ch_ready;
    logic          vram_we;
    logic [AW-1:0] vram_addr;
    logic [6:0]    vram_wdata;
    logic [6:0]    vram_rdata;

    modport slave (
        input  ch_valid,
        input  ch_data,
        output ch_ready,
        output vram_we,
        output vram_addr,
        output vram_wdata,
        input  vram_rdata
    );

    modport master (
        output ch_valid,
        output ch_data,
        input  ch_ready,
        input  vram_we,
        input  vram_addr,
        input  vram_wdata,
        output vram_rdata
    );
endinterface

// File: rtl/text_console_writer.sv
// ---------------------------------------------------------------------------
// text_console_writer
//
// Producer side of an 80x60 text-mode character RAM. Accepts 7-bit ASCII
// characters, keeps a cursor, writes glyph codes into the RAM and interprets
// CR, LF, BS and FF. Moving past the last row scrolls the screen up one row
// (read/write copy of rows 1..59 onto 0..58, then blank row 59).
//
// Ports:
//   sys_clk  - system clock
//   clrn     - asynchronous active-low reset
//   bus      - text_console_writer_if.slave (character stream + RAM port)
//   cur_row  - cursor row, 0..ROWS-1
//   cur_col  - cursor column, 0..COLS-1
//   busy     - scroll or clear in progress
//
// Build option:
//   CONSOLE_CLEAR_ON_RESET_EN - when defined, the screen is blanked (CLR)
//   right after reset instead of starting idle with RAM untouched.
// ---------------------------------------------------------------------------
module text_console_writer #(
    parameter int         COLS  = 80,
    parameter int         ROWS  = 60,
    parameter int         AW    = 13,
    parameter logic [6:0] BLANK = 7'h20
) (
    input  logic                   sys_clk,
    input  logic                   clrn,
    text_console_writer_if.slave   bus,
    output logic [5:0]             cur_row,
    output logic [6:0]             cur_col,
    output logic                   busy
);

    typedef enum logic [2:0] {IDLE, PUT, SCR_RD, SCR_WR, SCR_CLR, CLR} state_t;

`ifdef CONSOLE_CLEAR_ON_RESET_EN
    localparam state_t RESET_STATE = CLR;
`else
    localparam state_t RESET_STATE = IDLE;
`endif

    localparam logic [AW-1:0] SCR_CELLS = AW'((ROWS - 1) * COLS);
    localparam logic [AW-1:0] ALL_CELLS = AW'(ROWS * COLS);
    localparam logic [AW-1:0] ROW_STEP  = AW'(COLS);
    localparam logic [5:0]    LAST_ROW  = 6'(ROWS - 1);
    localparam logic [6:0]    LAST_COL  = 7'(COLS - 1);

    localparam logic [6:0] CH_BS = 7'h08;
    localparam logic [6:0] CH_LF = 7'h0A;
    localparam logic [6:0] CH_FF = 7'h0C;
    localparam logic [6:0] CH_CR = 7'h0D;

    state_t        state_reg, state_next;
    logic [5:0]    row_reg, row_next;
    logic [6:0]    col_reg, col_next;
    logic [AW-1:0] idx_reg, idx_next;     // cell index for scroll / clear
    logic [6:0]    char_reg, char_next;   // accepted character
    logic [6:0]    hold_reg, hold_next;   // cell read during scroll

    logic          we;
    logic [AW-1:0] addr;
    logic [6:0]    wdata;
    logic          printable;
    logic [AW-1:0] row_ext;
    logic [AW-1:0] cursor_addr;

    // row*80 as shift-and-add; this form assumes COLS == 80.
    assign row_ext     = AW'(row_reg);
    assign cursor_addr = (row_ext << 6) + (row_ext << 4) + AW'(col_reg);

    assign printable = (bus.ch_data >= 7'h20) && (bus.ch_data != 7'h7F);

    always_ff @(posedge sys_clk or negedge clrn) begin
        if (!clrn) begin
            state_reg <= RESET_STATE;
            row_reg   <= '0;
            col_reg   <= '0;
            idx_reg   <= '0;
            char_reg  <= '0;
            hold_reg  <= '0;
        end else begin
            state_reg <= state_next;
            row_reg   <= row_next;
            col_reg   <= col_next;
            idx_reg   <= idx_next;
            char_reg  <= char_next;
            hold_reg  <= hold_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        row_next   = row_reg;
        col_next   = col_reg;
        idx_next   = idx_reg;
        char_next  = char_reg;
        hold_next  = hold_reg;
        we         = 1'b0;
        addr       = '0;
        wdata      = '0;

        case (state_reg)
            IDLE: begin
                // ch_ready is high here, so ch_valid alone means a transfer.
                // Control codes are resolved on the accept edge itself.
                if (bus.ch_valid) begin
                    char_next = bus.ch_data;
                    if (printable) begin
                        state_next = PUT;
                    end else begin
                        case (bus.ch_data)
                            CH_LF: begin
                                col_next = '0;
                                if (row_reg < LAST_ROW) begin
                                    row_next = row_reg + 6'd1;
                                end else begin
                                    idx_next   = '0;
                                    state_next = SCR_RD;
                                end
                            end
                            CH_CR: col_next = '0;
                            CH_BS: begin
                                // No reverse wrap onto the previous row.
                                if (col_reg != '0) begin
                                    col_next   = col_reg - 7'd1;
                                    state_next = PUT;
                                end
                            end
                            CH_FF: begin
                                row_next   = '0;
                                col_next   = '0;
                                idx_next   = '0;
                                state_next = CLR;
                            end
                            default: ;
                        endcase
                    end
                end
            end

            PUT: begin
                we         = 1'b1;
                addr       = cursor_addr;
                state_next = IDLE;
                if (char_reg == CH_BS) begin
                    // Erase at the already-decremented cursor, no advance.
                    wdata = BLANK;
                end else begin
                    wdata = char_reg;
                    if (col_reg < LAST_COL) begin
                        col_next = col_reg + 7'd1;
                    end else begin
                        col_next = '0;
                        if (row_reg < LAST_ROW) begin
                            row_next = row_reg + 6'd1;
                        end else begin
                            idx_next   = '0;
                            state_next = SCR_RD;
                        end
                    end
                end
            end

            SCR_RD: begin
                // RAM read is combinational, so the cell below is captured now.
                addr       = idx_reg + ROW_STEP;
                hold_next  = bus.vram_rdata;
                state_next = SCR_WR;
            end

            SCR_WR: begin
                we         = 1'b1;
                addr       = idx_reg;
                wdata      = hold_reg;
                idx_next   = idx_reg + 1'b1;
                // idx continues into SCR_CLR at the first cell of the last row.
                state_next = (idx_reg == SCR_CELLS - 1'b1) ? SCR_CLR : SCR_RD;
            end

            SCR_CLR, CLR: begin
                we       = 1'b1;
                addr     = idx_reg;
                wdata    = BLANK;
                idx_next = idx_reg + 1'b1;
                if (idx_reg == ALL_CELLS - 1'b1) begin
                    idx_next   = '0;
                    state_next = IDLE;
                end
            end

            default: state_next = IDLE;
        endcase
    end

    assign bus.ch_ready   = (state_reg == IDLE);
    assign bus.vram_we    = we;
    assign bus.vram_addr  = addr;
    assign bus.vram_wdata = wdata;
    assign busy           = (state_reg == SCR_RD) || (state_reg == SCR_WR) ||
                            (state_reg == SCR_CLR) || (state_reg == CLR);
    assign cur_row        = row_reg;
    assign cur_col        = col_reg;

endmodule

// File: tb/tb_text_console_writer.sv
// ---------------------------------------------------------------------------
// tb_text_console_writer
//
// Bench for text_console_writer: holds the character RAM, a screen model
// (2-D array + cursor, scroll as a row copy) and a directed vector table,
// plus hand-written cycle sequences for accept latency, clear, scroll and
// reset-abort, and a randomized character stream checked against the model.
// ---------------------------------------------------------------------------
module tb_text_console_writer;
    localparam int COLS  = 80;
    localparam int ROWS  = 60;
    localparam int CELLS = COLS * ROWS;

`ifdef CONSOLE_CLEAR_ON_RESET_EN
    localparam bit CLR_ON_RST = 1'b1;
`else
    localparam bit CLR_ON_RST = 1'b0;
`endif

    logic       sys_clk = 1'b0;
    logic       clrn    = 1'b0;
    logic [5:0] cur_row;
    logic [6:0] cur_col;
    logic       busy;

    always #10 sys_clk = ~sys_clk;

    text_console_writer_if #(.AW(13)) bus ();

    text_console_writer dut (
        .sys_clk (sys_clk),
        .clrn    (clrn),
        .bus     (bus),
        .cur_row (cur_row),
        .cur_col (cur_col),
        .busy    (busy)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- character RAM ----------------
    logic [6:0]  vram [0:CELLS-1];
    int          wr_count = 0;
    logic [12:0] last_addr = '0;
    logic [6:0]  last_data = '0;
    logic        poke_en = 1'b0;
    logic [12:0] poke_addr = '0;
    logic [6:0]  poke_data = '0;

    assign bus.vram_rdata = (bus.vram_addr < 13'd4800) ? vram[bus.vram_addr] : 7'h00;

    always @(posedge sys_clk) begin
        if (poke_en) vram[poke_addr] <= poke_data;
        if (bus.vram_we) begin
            vram[bus.vram_addr] <= bus.vram_wdata;
            wr_count  <= wr_count + 1;
            last_addr <= bus.vram_addr;
            last_data <= bus.vram_wdata;
        end
    end

    // ---------------- screen model ----------------
    logic [6:0] scr [0:ROWS-1][0:COLS-1];
    int mrow = 0, mcol = 0, scrolls = 0;
    bit mput = 1'b0;

    task automatic model_blank();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) scr[r][c] = 7'h20;
    endtask

    task automatic model_newline();
        if (mrow < ROWS - 1) begin
            mrow++;
        end else begin
            for (int r = 0; r < ROWS - 1; r++)
                for (int c = 0; c < COLS; c++) scr[r][c] = scr[r+1][c];
            for (int c = 0; c < COLS; c++) scr[ROWS-1][c] = 7'h20;
            scrolls++;
        end
    endtask

    task automatic model_apply(input logic [6:0] ch);
        mput = 1'b0;
        if (ch >= 7'h20 && ch != 7'h7F) begin
            scr[mrow][mcol] = ch;
            mput = 1'b1;
            if (mcol == COLS - 1) begin
                mcol = 0;
                model_newline();
            end else begin
                mcol++;
            end
        end else if (ch == 7'h0A) begin
            mcol = 0;
            model_newline();
        end else if (ch == 7'h0D) begin
            mcol = 0;
        end else if (ch == 7'h08) begin
            if (mcol > 0) begin
                mcol--;
                scr[mrow][mcol] = 7'h20;
                mput = 1'b1;
            end
        end else if (ch == 7'h0C) begin
            mrow = 0;
            mcol = 0;
            model_blank();
        end
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic compare_screen(input string name);
        int bad;
        int first;
        bad = 0;
        first = -1;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (vram[r*COLS+c] !== scr[r][c]) begin
                    if (first < 0) first = r * COLS + c;
                    bad++;
                end
        if (bad != 0)
            $display("  screen %s: first differing cell %0d ram=0x%0h model=0x%0h",
                     name, first, vram[first], scr[first/COLS][first%COLS]);
        chk(name, bad, 0);
    endtask

    task automatic wait_idle(output int nbusy);
        int t;
        nbusy = 0;
        t = 0;
        @(negedge sys_clk);
        while (!bus.ch_ready && t < 20000) begin
            if (busy) nbusy++;
            t++;
            @(negedge sys_clk);
        end
        if (!bus.ch_ready) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: ch_ready=%0b after %0d cycles, required 1", bus.ch_ready, t);
        end
    endtask

    task automatic send(input logic [6:0] ch, output int nwr, output int laddr,
                        output int ldata, output int nbusy);
        int t;
        int w0;
        nwr = 0; laddr = 0; ldata = 0; nbusy = 0;
        @(negedge sys_clk);
        bus.ch_valid = 1'b1;
        bus.ch_data  = ch;
        t = 0;
        while (!bus.ch_ready && t < 20000) begin
            @(negedge sys_clk);
            t++;
        end
        if (!bus.ch_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: ch_ready=%0b after %0d cycles, required 1", bus.ch_ready, t);
            bus.ch_valid = 1'b0;
        end else begin
            w0 = wr_count;
            @(posedge sys_clk);
            #1;
            bus.ch_valid = 1'b0;
            wait_idle(nbusy);
            nwr   = wr_count - w0;
            laddr = int'(last_addr);
            ldata = int'(last_data);
            model_apply(ch);
            $display("tx ch=0x%02h -> row %0d col %0d, %0d writes, %0d busy cycles",
                     ch, cur_row, cur_col, nwr, nbusy);
        end
    endtask

    task automatic do_reset();
        int nb;
        @(negedge sys_clk);
        bus.ch_valid = 1'b0;
        clrn = 1'b0;
        @(negedge sys_clk);
        clrn = 1'b1;
        mrow = 0;
        mcol = 0;
        if (CLR_ON_RST) model_blank();
        wait_idle(nb);
    endtask

    task automatic goto_pos(input int r, input int c);
        int a, b, d, e;
        do_reset();
        for (int k = 0; k < r; k++) send(7'h0A, a, b, d, e);
        for (int k = 0; k < c; k++) send(7'h2E, a, b, d, e);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        int         r0;
        int         c0;
        logic [6:0] ch;
        int         nwr;
        int         addr;
        int         data;
        int         row;
        int         col;
        int         nbusy;
    } vec_t;

    vec_t vecs [12];

    initial begin
        int nwr, la, ld, nb, t, k, bad;
        logic [6:0] ch;
        int pre, r;

        bus.ch_valid = 1'b0;
        bus.ch_data  = 7'h00;

        // ---- reset state, sampled while clrn is held low ----
        repeat (3) @(negedge sys_clk);
`ifdef CONSOLE_CLEAR_ON_RESET_EN
        chk("rst_ready", int'(bus.ch_ready), 0);
        chk("rst_busy", int'(busy), 1);
`else
        chk("rst_ready", int'(bus.ch_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_we", int'(bus.vram_we), 0);
        chk("rst_addr", int'(bus.vram_addr), 0);
        chk("rst_wdata", int'(bus.vram_wdata), 0);
`endif
        chk("rst_row", int'(cur_row), 0);
        chk("rst_col", int'(cur_col), 0);
        clrn = 1'b1;
        if (CLR_ON_RST) model_blank();
        wait_idle(nb);

        // ---- FF: 4800 sequential blank writes, input held off meanwhile ----
        @(negedge sys_clk);
        bus.ch_valid = 1'b1;
        bus.ch_data  = 7'h0C;
        t = 0;
        while (!bus.ch_ready && t < 100) begin @(negedge sys_clk); t++; end
        @(posedge sys_clk);
        #1;
        bus.ch_data = 7'h51;        // 'Q' stays offered throughout the clear
        k = 0;
        bad = 0;
        @(negedge sys_clk);
        while (busy && k < 6000) begin
            if (!(bus.vram_we && int'(bus.vram_addr) == k && bus.vram_wdata == 7'h20 &&
                  !bus.ch_ready && cur_row == 6'd0 && cur_col == 7'd0)) bad++;
            k++;
            @(negedge sys_clk);
        end
        chk("ff_cycles", k, 4800);
        chk("ff_bad_cycles", bad, 0);
        @(posedge sys_clk);          // 'Q' accepted once idle
        #1;
        bus.ch_valid = 1'b0;
        wait_idle(nb);
        model_apply(7'h0C);
        model_apply(7'h51);
        $display("tx ch=0x0c then 0x51 -> row %0d col %0d", cur_row, cur_col);
        chk("ff_q_col", int'(cur_col), 1);
        chk("ff_q_row", int'(cur_row), 0);
        compare_screen("ff_screen");

        // ---- table-driven single characters ----
        vecs[0]  = '{0,  0,  7'h41, 1, 0,    7'h41, 0,  1,  0};
        vecs[1]  = '{3,  79, 7'h5A, 1, 319,  7'h5A, 4,  0,  0};
        vecs[2]  = '{10, 5,  7'h08, 1, 804,  7'h20, 10, 4,  0};
        vecs[3]  = '{10, 0,  7'h08, 0, 0,    0,     10, 0,  0};
        vecs[4]  = '{7,  20, 7'h0D, 0, 0,    0,     7,  0,  0};
        vecs[5]  = '{7,  20, 7'h0A, 0, 0,    0,     8,  0,  0};
        vecs[6]  = '{2,  2,  7'h7F, 0, 0,    0,     2,  2,  0};
        vecs[7]  = '{2,  2,  7'h00, 0, 0,    0,     2,  2,  0};
        vecs[8]  = '{58, 79, 7'h71, 1, 4719, 7'h71, 59, 0,  0};
        vecs[9]  = '{59, 0,  7'h7E, 1, 4720, 7'h7E, 59, 1,  0};
        vecs[10] = '{5,  0,  7'h20, 1, 400,  7'h20, 5,  1,  0};
        vecs[11] = '{12, 40, 7'h1B, 0, 0,    0,     12, 40, 0};
        for (int i = 0; i < 12; i++) begin
            goto_pos(vecs[i].r0, vecs[i].c0);
            send(vecs[i].ch, nwr, la, ld, nb);
            chk($sformatf("vec%0d_writes", i), nwr, vecs[i].nwr);
            if (vecs[i].nwr != 0) begin
                chk($sformatf("vec%0d_addr", i), la, vecs[i].addr);
                chk($sformatf("vec%0d_data", i), ld, vecs[i].data);
            end
            chk($sformatf("vec%0d_row", i), int'(cur_row), vecs[i].row);
            chk($sformatf("vec%0d_col", i), int'(cur_col), vecs[i].col);
            chk($sformatf("vec%0d_busy", i), nb, vecs[i].nbusy);
        end
        compare_screen("table_screen");

        // ---- accept latency and back-to-back throughput, valid held high ----
        do_reset();
        @(negedge sys_clk);
        chk("t1_ready_before", int'(bus.ch_ready), 1);
        bus.ch_valid = 1'b1;
        bus.ch_data  = 7'h41;
        @(negedge sys_clk);
        chk("t1_put_we", int'(bus.vram_we), 1);
        chk("t1_put_addr", int'(bus.vram_addr), 0);
        chk("t1_put_data", int'(bus.vram_wdata), 8'h41);
        chk("t1_put_ready", int'(bus.ch_ready), 0);
        @(negedge sys_clk);
        chk("t1_ready_again", int'(bus.ch_ready), 1);
        chk("t1_col", int'(cur_col), 1);
        chk("t1_idle_we", int'(bus.vram_we), 0);
        @(negedge sys_clk);
        chk("t1_second_we", int'(bus.vram_we), 1);
        chk("t1_second_addr", int'(bus.vram_addr), 1);
        bus.ch_valid = 1'b0;
        wait_idle(nb);
        model_apply(7'h41);
        model_apply(7'h41);
        $display("tx ch=0x41 x2 held valid -> row %0d col %0d", cur_row, cur_col);
        chk("t1_col_after2", int'(cur_col), 2);

        // ---- scroll with last row pre-loaded with 'x' ----
        goto_pos(59, 3);
        for (int c = 0; c < COLS; c++) begin
            @(negedge sys_clk);
            poke_en   = 1'b1;
            poke_addr = 13'(4720 + c);
            poke_data = 7'h78;
            scr[59][c] = 7'h78;
        end
        @(negedge sys_clk);
        poke_en = 1'b0;
        send(7'h0A, nwr, la, ld, nb);
        chk("scr_busy_cycles", nb, 9520);
        chk("scr_writes", nwr, 4800);
        chk("scr_row", int'(cur_row), 59);
        chk("scr_col", int'(cur_col), 0);
        bad = 0;
        for (int a = 4640; a < 4720; a++) if (vram[a] !== 7'h78) bad++;
        chk("scr_row58_x", bad, 0);
        bad = 0;
        for (int a = 4720; a < 4800; a++) if (vram[a] !== 7'h20) bad++;
        chk("scr_row59_blank", bad, 0);
        compare_screen("scroll_screen");

        // ---- randomized stream against the model ----
        goto_pos(57, 0);
        scrolls = 0;
        for (int i = 0; i < 90; i++) begin
            r = $urandom_range(0, 99);
            if (r < 6)       ch = 7'h0A;
            else if (r < 10) ch = 7'h0D;
            else if (r < 18) ch = 7'h08;
            else if (r < 22) begin
                ch = 7'($urandom_range(0, 31));
                if (ch == 7'h08 || ch == 7'h0A || ch == 7'h0C || ch == 7'h0D) ch = 7'h7F;
            end else ch = 7'($urandom_range(32, 126));
            // keep the run short: no more than three scrolls
            if (scrolls >= 3 && mrow == ROWS - 1 &&
                (ch == 7'h0A || (ch >= 7'h20 && ch != 7'h7F && mcol == COLS - 1)))
                ch = 7'h0D;
            pre = scrolls;
            send(ch, nwr, la, ld, nb);
            chk($sformatf("rnd%0d_row", i), int'(cur_row), mrow);
            chk($sformatf("rnd%0d_col", i), int'(cur_col), mcol);
            chk($sformatf("rnd%0d_writes", i), nwr, (mput ? 1 : 0) + (scrolls - pre) * CELLS);
            chk($sformatf("rnd%0d_busy", i), nb, (scrolls - pre) * 9520);
        end
        compare_screen("random_screen");

        // ---- reset asserted mid-scroll (at cell 1000) ----
        goto_pos(59, 5);
        @(negedge sys_clk);
        bus.ch_valid = 1'b1;
        bus.ch_data  = 7'h0A;
        @(posedge sys_clk);
        #1;
        bus.ch_valid = 1'b0;
        t = 0;
        @(negedge sys_clk);
        while (!(bus.vram_we && bus.vram_addr == 13'd1000) && t < 5000) begin
            t++;
            @(negedge sys_clk);
        end
        if (!(bus.vram_we && bus.vram_addr == 13'd1000)) begin
            checks++;
            errors++;
            $display("FAIL abort_reach: scroll did not reach cell 1000 after %0d cycles", t);
        end
        clrn = 1'b0;
        #1;
        $display("tx reset during scroll at cell %0d", bus.vram_addr);
`ifdef CONSOLE_CLEAR_ON_RESET_EN
        chk("abort_busy", int'(busy), 1);
        chk("abort_ready", int'(bus.ch_ready), 0);
        chk("abort_addr", int'(bus.vram_addr), 0);
`else
        chk("abort_busy", int'(busy), 0);
        chk("abort_ready", int'(bus.ch_ready), 1);
        chk("abort_we", int'(bus.vram_we), 0);
        chk("abort_addr", int'(bus.vram_addr), 0);
        chk("abort_wdata", int'(bus.vram_wdata), 0);
`endif
        chk("abort_row", int'(cur_row), 0);
        chk("abort_col", int'(cur_col), 0);
        @(negedge sys_clk);
        clrn = 1'b1;
        wait_idle(nb);
        chk("abort_idle_busy", int'(busy), 0);
        chk("abort_idle_ready", int'(bus.ch_ready), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
